alu_muldiv_sequencer: RTL and testbench

Multi-cycle controller that sequences the shared 16-bit datapath ALU to execute unsigned 16×16 multiply (shift-add) and unsigned 16/16 divide (restoring) for the EX stage. It owns the ALU's X/Y/opcode inputs while running, reads back sum/carry each cycle, and accumulates a 32-bit result in HI/LO registers. The pipeline uses `busy` as a stall and captures HI/LO on `done`.

---
 rtl/alu_muldiv_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_sequencer.sv
// Sequences the shared 16-bit ALU through shift-add multiply
// and restoring divide, accumulating a 32-bit HI/LO result.
module alu_muldiv_sequencer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_hi,
  output logic [15:0] o_lo,
  output logic        o_div_by_zero,
  output logic [15:0] o_alu_x,
  output logic [15:0] o_alu_y,
  output logic [2:0]  o_alu_opcod,
  input  logic [15:0] i_alu_out,
  input  logic        i_alu_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_hi;
  logic [15:0] r_lo;
  logic [15:0] r_opnd;
  logic        r_op;
  logic        r_dbz;

  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [2:0]  w_opc;
  logic        w_run;
  logic        w_ge;
  logic [16:0] w_sum;

  assign w_run = (r_state == S_RUN);

  // ALU drive depends only on registered state, never on i_start
  always_comb begin
    w_x   = 16'h0000;
    w_y   = 16'h0000;
    w_opc = OP_ADD;
    if (w_run) begin
      if (!r_op) begin
        w_x = r_hi;
        w_y = r_lo[0] ? r_opnd : 16'h0000;
      end else begin
        w_opc = OP_SUB;
        w_x   = {r_hi[14:0], r_lo[15]};
        w_y   = r_opnd;
      end
    end
  end

  assign w_sum = {i_alu_cout, i_alu_out};
  // hi[15] set means the shifted remainder already exceeds 16 bits
  assign w_ge  = r_hi[15] | i_alu_cout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hi    <= 16'h0000;
      r_lo    <= 16'h0000;
      r_opnd  <= 16'h0000;
      r_op    <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op   <= i_op;
            r_opnd <= i_b;
            r_cnt  <= 4'd0;
            if (i_op && (i_b == 16'h0000)) begin
              r_hi    <= i_a;
              r_lo    <= 16'hFFFF;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_hi    <= 16'h0000;
              r_lo    <= i_a;
              r_dbz   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!r_op) begin
            r_hi <= w_sum[16:1];
            r_lo <= {w_sum[0], r_lo[15:1]};
          end else begin
            r_hi <= w_ge ? i_alu_out : w_x;
            r_lo <= {r_lo[14:0], w_ge};
          end
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = w_run;
  assign o_done        = (r_state == S_DONE);
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_dbz;
  assign o_alu_x       = w_x;
  assign o_alu_y       = w_y;
  assign o_alu_opcod   = w_opc;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with an add/sub ALU
// model closing the loop.
module tb_alu_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        dbz;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [2:0]  alu_opcod;
  logic [15:0] alu_out;
  logic        alu_cout;

  int n_chk;
  int n_pass;

  alu_muldiv_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .o_busy        (busy),
    .o_done        (done),
    .o_hi          (hi),
    .o_lo          (lo),
    .o_div_by_zero (dbz),
    .o_alu_x       (alu_x),
    .o_alu_y       (alu_y),
    .o_alu_opcod   (alu_opcod),
    .i_alu_out     (alu_out),
    .i_alu_cout    (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] alu_s;
  always_comb begin
    alu_s = 17'd0;
    if (alu_opcod == 3'b001)
      alu_s = {1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1;
    else
      alu_s = {1'b0, alu_x} + {1'b0, alu_y};
  end
  assign alu_out  = alu_s[15:0];
  assign alu_cout = alu_s[16];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic run_op(input string tag,
                        input logic i_op,
                        input logic [15:0] i_a,
                        input logic [15:0] i_b,
                        input logic [15:0] e_hi,
                        input logic [15:0] e_lo,
                        input logic e_dbz,
                        input int glitch_cyc);
    int cyc;
    int nbusy;
    int e_cyc;
    e_cyc = e_dbz ? 1 : 17;
    @(negedge clk);
    start = 1'b1;
    op    = i_op;
    a     = i_a;
    b     = i_b;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    if (!e_dbz)
      chk({tag, "_opc"}, {29'd0, alu_opcod}, {31'd0, i_op});
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      if (cyc == glitch_cyc) begin
        start = 1'b1;
        op    = ~i_op;
        a     = 16'hDEAD;
        b     = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, cyc, e_cyc);
    chk({tag, "_busy_cnt"}, nbusy, e_dbz ? 0 : 16);
    chk({tag, "_hi"}, {16'd0, hi}, {16'd0, e_hi});
    chk({tag, "_lo"}, {16'd0, lo}, {16'd0, e_lo});
    chk({tag, "_dbz"}, {31'd0, dbz}, {31'd0, e_dbz});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold_lo"}, {16'd0, lo}, {16'd0, e_lo});
  endtask

  initial begin
    logic saw_done;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    a      = 16'h0000;
    b      = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hilo", {hi, lo}, 32'd0);
    chk("rst_alu", {alu_x, alu_y}, 32'd0);
    rst = 1'b0;

    run_op("mul3x5", 1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F, 1'b0, 0);
    run_op("mulFF", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 0);
    run_op("mul1234", 1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 0);
    run_op("div100_7", 1'b1, 16'd100, 16'd7, 16'h0002, 16'h000E, 1'b0, 0);
    run_op("divFFFF", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 0);
    run_op("div0", 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 0);
    chk("div0_alu_idle", {13'd0, alu_opcod, alu_x}, 32'd0);
    run_op("div6_3", 1'b1, 16'h0006, 16'h0003, 16'h0000, 16'h0002, 1'b0, 0);
    run_op("mul_glitch", 1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F, 1'b0, 5);

    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'd100;
    b     = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hilo", {hi, lo}, 32'd0);
    chk("abort_dbz", {31'd0, dbz}, 32'd0);
    chk("abort_alu", {alu_x, alu_y}, 32'd0);
    chk("abort_opc", {29'd0, alu_opcod}, 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_op("mul9x9", 1'b0, 16'h0009, 16'h0009, 16'h0000, 16'h0051, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
